// File: rtl/instr_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// instr_fifo_arbiter
//
// Shares the write port of the instruction FIFO between N_REQ independent
// instruction producers. Requesters are granted round-robin, one word per
// grant. A granted word is latched in IDLE and written in WRITE once the FIFO
// is not full. No word is ever dropped or written twice.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   req         per-requester write request (level, held until ack)
//   data_in     requester i's word in bits [i*DATA_W +: DATA_W]
//   ack         one-cycle pulse: the requester's word is written this cycle
//   fifo_full   FIFO write-side full flag
//   fifo_wrreq  FIFO write enable
//   fifo_data   FIFO write data (latched word of the granted requester)
//   busy        high while a granted word is waiting to be written
//   grant_id    index of the current/last granted requester
// -----------------------------------------------------------------------------
module instr_fifo_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 64,
    parameter int PTR_W  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data_in,
    output logic [N_REQ-1:0]          ack,
    input  logic                      fifo_full,
    output logic                      fifo_wrreq,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      busy,
    output logic [PTR_W-1:0]          grant_id
);

    localparam int PAD_W = 1 << PTR_W;

    generate
        if (N_REQ < 2 || PAD_W < N_REQ) begin : g_param_error
            $error("instr_fifo_arbiter: need N_REQ >= 2 and 2**PTR_W >= N_REQ");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PAD_W-1:0]   req_pad;
    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic [DATA_W-1:0]  sel_data;

    // req widened to the full index range so that a PTR_W-bit index always
    // selects a real bit; the padding bits are never requesting.
    always_comb begin
        req_pad = '0;
        req_pad[N_REQ-1:0] = req;
    end

    // Round-robin scan: first requesting index starting at rr_ptr, wrapping
    // modulo N_REQ.
    // NOTE: every signal driven from an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!sel_valid && req_pad[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Word of the selected requester; constant slices keep the mux simple.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state and the WRITE-state outputs. The FIFO full flag is sampled
    // combinationally so a flag rising in the write cycle still blocks it.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        busy       = 1'b0;
        fifo_wrreq = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy       = 1'b1;
                fifo_wrreq = ~fifo_full & req_pad[grant_id];
                if (fifo_wrreq) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id == PTR_W'(N_REQ - 1)) ? '0
                                                               : grant_id + PTR_W'(1);
                end else if (!req_pad[grant_id]) begin
                    // Requester withdrew before being served: no write, and
                    // its priority position is left untouched.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the granted requester can see ack, and only in its write cycle.
    always_comb begin
        ack = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = fifo_wrreq && (grant_id == PTR_W'(i));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_id  <= '0;
            fifo_data <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (state_q == IDLE && sel_valid) begin
                grant_id  <= sel_idx;
                fifo_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_instr_fifo_arbiter
//
// Self-checking bench for instr_fifo_arbiter (N_REQ=4). A reference model
// predicts every FIFO write and pushes it into a scoreboard queue; a separate
// monitor pops an entry whenever the DUT asserts fifo_wrreq and compares.
// Directed phases cover latency, alternation, back-pressure, abort, async
// reset and fairness; a long randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instr_fifo_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 64;
    localparam int PTR_W  = 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [N_REQ-1:0]         req = '0;
    logic [N_REQ*DATA_W-1:0]  data_in = '0;
    logic                     fifo_full = 1'b0;
    logic [N_REQ-1:0]         ack;
    logic                     fifo_wrreq;
    logic [DATA_W-1:0]        fifo_data;
    logic                     busy;
    logic [PTR_W-1:0]         grant_id;

    instr_fifo_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               gid;
        logic [DATA_W-1:0] data;
        int               cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    wr_t e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_writes = 0;
    int word_ctr = 0;

    // Reference model: a pending grant (or none) and a priority pointer.
    bit               m_busy = 1'b0;
    int               m_ptr  = 0;
    int               m_gid  = 0;
    logic [DATA_W-1:0] m_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] new_word(input int i);
        word_ctr++;
        return {8'(i), 24'h0, 32'(word_ctr)};
    endfunction

    always @(posedge clk) cyc++;

    // Model state update at the clock edge, from the pre-edge inputs.
    always @(posedge clk or negedge reset) begin
        bit found;
        if (!reset) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_gid  = 0;
            m_data = '0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req[(m_ptr + k) % N_REQ]) begin
                    found  = 1'b1;
                    m_gid  = (m_ptr + k) % N_REQ;
                    m_data = data_in[m_gid*DATA_W +: DATA_W];
                    m_busy = 1'b1;
                end
            end
        end else if (!fifo_full && req[m_gid]) begin
            m_ptr  = (m_gid + 1) % N_REQ;
            m_busy = 1'b0;
        end else if (!req[m_gid]) begin
            m_busy = 1'b0;
        end
    end

    // Mid-cycle model comparison and scoreboard push.
    always @(negedge clk) begin
        bit               ew;
        logic [N_REQ-1:0] ea;
        ew = reset && m_busy && !fifo_full && req[m_gid];
        ea = '0;
        if (ew) ea[m_gid] = 1'b1;
        check("busy", 64'(busy), 64'(m_busy));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("fifo_data", fifo_data, m_data);
        check("fifo_wrreq", 64'(fifo_wrreq), 64'(ew));
        check("ack", 64'(ack), 64'(ea));
        if (ew) exp_q.push_back('{m_gid, m_data, cyc});
    end

    // Monitor: pops the scoreboard whenever the DUT writes the FIFO.
    always @(negedge clk) begin
        logic [N_REQ-1:0] oh;
        #1;
        if (fifo_wrreq === 1'b1) begin
            oh = '0;
            oh[grant_id] = 1'b1;
            check("sb_pending", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_gid", 64'(grant_id), 64'(e.gid));
                check("sb_data", fifo_data, e.data);
                check("sb_cycle", 64'(cyc), 64'(e.cyc));
                check("sb_ack", 64'(ack), 64'(oh));
            end
            log_q.push_back('{int'(grant_id), fifo_data, cyc});
            n_writes++;
        end
    end

    // One cycle of requester behaviour per iteration (percent probabilities).
    task automatic run_cycles(input int n, input int p_new, input int p_hold,
                              input int p_abort, input int p_full);
        logic [N_REQ-1:0] a;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #2;
            a = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (a[i]) begin
                    if ($urandom_range(99) < p_hold) data_in[i*DATA_W +: DATA_W] = new_word(i);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(99) < p_new) begin
                        req[i] = 1'b1;
                        data_in[i*DATA_W +: DATA_W] = new_word(i);
                    end
                end else if ($urandom_range(99) < p_abort) begin
                    req[i] = 1'b0;
                end
            end
            fifo_full = ($urandom_range(99) < p_full);
        end
    endtask

    task automatic run_writes(input int target, input int p_new, input int p_hold,
                              input int p_abort, input int p_full, input int budget);
        int base;
        base = n_writes;
        for (int c = 0; c < budget && (n_writes - base) < target; c++) begin
            run_cycles(1, p_new, p_hold, p_abort, p_full);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic go_idle(input int n);
        @(posedge clk);
        #1;
        req = '0;
        fifo_full = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int wbase;
        int dups;
        logic [DATA_W-1:0] w;

        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_wrreq", 64'(fifo_wrreq), 64'(0));
        check("rst_data", fifo_data, 64'(0));
        reset = 1'b1;

        // Single request from requester 0, word 1.
        req[0] = 1'b1;
        data_in[0 +: DATA_W] = 64'h1;
        base = log_q.size();
        run_cycles(4, 0, 0, 0, 0);
        check("t1_writes", 64'(log_q.size() - base), 64'(1));
        if (log_q.size() > base) begin
            check("t1_gid", 64'(log_q[base].gid), 64'(0));
            check("t1_data", log_q[base].data, 64'h1);
        end

        // Two requesters held continuously: pointer now favours requester 1.
        req[1:0] = 2'b11;
        data_in[0 +: DATA_W] = new_word(0);
        data_in[DATA_W +: DATA_W] = new_word(1);
        base = log_q.size();
        run_writes(8, 0, 100, 0, 0, 40);
        check("t2_writes", 64'(log_q.size() - base), 64'(8));
        for (int k = 0; k + 1 < 8 && base + k + 1 < log_q.size(); k++) begin
            check("t2_alt", 64'(log_q[base+k].gid), 64'((1 + k) % 2));
            check("t2_spacing", 64'(log_q[base+k+1].cyc - log_q[base+k].cyc), 64'(2));
        end
        go_idle(3);

        // Back-pressure: requester 1 waits 5 cycles on a full FIFO.
        do_reset();
        req[1] = 1'b1;
        w = new_word(1);
        data_in[DATA_W +: DATA_W] = w;
        fifo_full = 1'b1;
        wbase = n_writes;
        run_cycles(5, 0, 0, 0, 100);
        check("t3_blocked", 64'(n_writes - wbase), 64'(0));
        check("t3_busy", 64'(busy), 64'(1));
        base = log_q.size();
        run_cycles(3, 0, 0, 0, 0);
        check("t3_writes", 64'(log_q.size() - base), 64'(1));
        if (log_q.size() > base) begin
            check("t3_gid", 64'(log_q[base].gid), 64'(1));
            check("t3_data", log_q[base].data, w);
        end
        go_idle(2);

        // Abort: requester 0 withdraws while the FIFO is full.
        do_reset();
        req[0] = 1'b1;
        data_in[0 +: DATA_W] = new_word(0);
        fifo_full = 1'b1;
        wbase = n_writes;
        run_cycles(3, 0, 0, 0, 100);
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        run_cycles(2, 0, 0, 0, 100);
        check("t4_no_write", 64'(n_writes - wbase), 64'(0));
        check("t4_idle", 64'(busy), 64'(0));
        req[1:0] = 2'b11;
        data_in[0 +: DATA_W] = new_word(0);
        data_in[DATA_W +: DATA_W] = new_word(1);
        fifo_full = 1'b0;
        base = log_q.size();
        run_writes(2, 0, 0, 0, 0, 20);
        check("t4_writes", 64'(log_q.size() - base), 64'(2));
        if (log_q.size() > base + 1) begin
            check("t4_first", 64'(log_q[base].gid), 64'(0));
            check("t4_second", 64'(log_q[base+1].gid), 64'(1));
        end
        go_idle(2);

        // Asynchronous reset in the middle of a blocked write.
        do_reset();
        req[0] = 1'b1;
        data_in[0 +: DATA_W] = new_word(0);
        fifo_full = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check("t5_busy_before", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_wrreq", 64'(fifo_wrreq), 64'(0));
        check("t5_ack", 64'(ack), 64'(0));
        check("t5_gid", 64'(grant_id), 64'(0));
        check("t5_data", fifo_data, 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        fifo_full = 1'b0;
        wbase = n_writes;
        run_cycles(6, 0, 0, 0, 0);
        check("t5_one_write", 64'(n_writes - wbase), 64'(1));
        go_idle(2);

        // Fairness: all four requesting continuously for 16 writes.
        do_reset();
        req = '1;
        for (int i = 0; i < N_REQ; i++) data_in[i*DATA_W +: DATA_W] = new_word(i);
        base = log_q.size();
        run_writes(16, 100, 100, 0, 0, 100);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_writes", 64'(log_q.size() - base), 64'(16));
        dups = 0;
        for (int k = 0; k < 16 && base + k < log_q.size(); k++) begin
            check("t6_order", 64'(log_q[base+k].gid), 64'(k % N_REQ));
            check("t6_owner", 64'(log_q[base+k].data[63:56]), 64'(log_q[base+k].gid));
            for (int j = 0; j < k; j++) begin
                if (log_q[base+j].data == log_q[base+k].data) dups++;
            end
        end
        check("t6_no_dup", 64'(dups), 64'(0));

        // Randomized traffic with back-pressure, aborts and held requests.
        do_reset();
        run_cycles(3000, 30, 50, 5, 30);
        go_idle(4);
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fifo_arbiter.md
Name: instr_fifo_arbiter

Overview:
Shares the write port of the instruction FIFO between N_REQ independent instruction producers, e.g. the host bridge and on-chip game logic. The FIFO's read side feeds the control unit through fifo_empty/rdreg. Grants are round-robin, one instruction word per grant. The block back-pressures on fifo_full and never drops or duplicates a word.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 64, instruction word width (opcode plus operands, as written to the FIFO)
PTR_W, 3, width of grant index and round-robin pointer; must satisfy 2^PTR_W >= N_REQ

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester write request; level, held until ack
data_in  in  N_REQ*DATA_W  requester i's word in bits [i*DATA_W +: DATA_W]; stable while req[i] high
ack  out  N_REQ  one-cycle pulse: requester's word written into the FIFO this cycle
fifo_full  in  1  FIFO write-side full flag
fifo_wrreq  out  1  FIFO write enable
fifo_data  out  DATA_W  FIFO write data
busy  out  1  high while in WRITE state
grant_id  out  PTR_W  index of the current/last granted requester

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE
  - rr_ptr=0 (highest priority = requester 0)
  - grant_id=0, fifo_data=0
  - ack=0, fifo_wrreq=0, busy=0
- States: IDLE, WRITE.
- IDLE:
  - When any req bit is high at a rising edge, select the first requester with req high, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - At that edge: latch its data_in into fifo_data, set grant_id, go to WRITE.
  - No request: stay in IDLE; fifo_data holds its last value.
- WRITE (combinational outputs):
  - busy=1.
  - fifo_wrreq = ~fifo_full & req[grant_id].
  - ack[grant_id] = fifo_wrreq; all other ack bits are 0.
- WRITE transitions:
  - fifo_wrreq=1: at the edge, rr_ptr = (grant_id+1) mod N_REQ, then go to IDLE.
  - fifo_full=1: stay in WRITE with wrreq=0; fifo_data and grant_id are held. No timeout.
  - req[grant_id] drops before ack (abort): go to IDLE at the next edge. No write, no ack, rr_ptr unchanged.
- Latency and throughput:
  - req rising before edge N gives fifo_wrreq/ack during cycle N+1 if the FIFO is not full.
  - Minimum 2 cycles per word per arbiter; maximum throughput is 1 word per 2 cycles.
- Requester protocol:
  - Sample ack at the rising edge.
  - On ack, either drop req or present the next word with req held high.
  - A held req is re-arbitrated in IDLE. Its priority is now last, so another pending requester wins first.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0,... Each requester waits at most N_REQ-1 grants.
- Simultaneous events:
  - New req bits arriving during WRITE are ignored until IDLE.
  - fifo_full rising in the same cycle as a pending write suppresses the write; the FIFO flag is authoritative.
- Reset mid-WRITE: the latched word is discarded and no ack is issued. The requester keeps req high and is re-arbitrated after reset.
- ack is never asserted for more than one requester, or for more than one cycle per word.
- Parameter check: N_REQ < 2 or 2^PTR_W < N_REQ is an elaboration error.

Test Plan:
1. Reset, then req=01 with data0=64'h1 and fifo_full=0: fifo_wrreq and ack=01 in the 2nd cycle after req, fifo_data=64'h1, grant_id=0, then IDLE and rr_ptr=1.
2. req=11 held continuously with data0=A, data1=B (new value after each ack): FIFO receives A,B,A,B,... with acks alternating 01,10 every 2 cycles.
3. Single request to requester 1 with fifo_full=1 for 5 cycles: busy=1, wrreq=0 and ack=0 throughout; the write fires in the first cycle after fifo_full=0 with the data unchanged.
4. Grant to requester 0, then req[0] dropped while fifo_full=1: back to IDLE, no ack, rr_ptr still 0; a next req=11 grants requester 0 first.
5. reset pulsed low during WRITE with fifo_full=1: all outputs 0 immediately (async); after release with req still high, the write completes normally with exactly one ack.
6. N_REQ=4, req=1111 for 16 writes: grant order 0,1,2,3 repeated 4×; exactly 16 fifo_wrreq pulses, no duplicates.
